// File: rtl/cim_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cim_pkg : shared types and constants for the CNN layer pipeline     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package cim_pkg;

  localparam int DATATYPE_SIZE = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } argmax_state_t;

endpackage
`default_nettype wire

// File: rtl/argmax_layer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | argmax_layer_if : element stream in, classification result out     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface argmax_layer_if #(
  parameter int datatype_size = 2,
  parameter int idx_width     = 4
);
  logic                     i_we;
  logic [datatype_size-1:0] i_data;
  logic                     i_ack;
  logic                     o_busy;
  logic                     o_valid;
  logic [idx_width-1:0]     o_class;
  logic [datatype_size-1:0] o_max;
  logic                     o_overrun;

  modport master (
    output i_we, i_data, i_ack,
    input  o_busy, o_valid, o_class, o_max, o_overrun
  );

  modport slave (
    input  i_we, i_data, i_ack,
    output o_busy, o_valid, o_class, o_max, o_overrun
  );
endinterface
`default_nettype wire

// File: rtl/argmax_layer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | argmax_layer : running max/index over a serial activation stream   |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module argmax_layer
  import cim_pkg::*;
#(
  parameter int output_size   = 10,
  parameter int datatype_size = cim_pkg::DATATYPE_SIZE,
  parameter int idx_width     = (output_size > 1) ? $clog2(output_size) : 1
) (
  input  wire logic     clk,
  input  wire logic     rst,
  argmax_layer_if.slave bus
);

  localparam logic [idx_width:0] C_LAST = (idx_width+1)'(output_size - 1);
  localparam logic [idx_width:0] C_ONE  = (idx_width+1)'(1);

  argmax_state_t            r_state;
  argmax_state_t            w_next;
  logic [datatype_size-1:0] r_max_val;
  logic [idx_width-1:0]     r_max_idx;
  logic [idx_width:0]       r_cnt;
  logic                     r_overrun;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_we) w_next = (output_size == 1) ? ST_HOLD : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (bus.i_we && (r_cnt == C_LAST)) w_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.i_ack) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Strict '>' keeps the earliest index on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max_val <= '0;
      r_max_idx <= '0;
      r_cnt     <= '0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.i_we) begin
            r_max_val <= bus.i_data;
            r_max_idx <= '0;
            r_cnt     <= C_ONE;
          end
        end
        ST_ACCUM: begin
          if (bus.i_we) begin
            if (bus.i_data > r_max_val) begin
              r_max_val <= bus.i_data;
              r_max_idx <= r_cnt[idx_width-1:0];
            end
            r_cnt <= r_cnt + C_ONE;
          end
        end
        ST_HOLD: begin
          if (bus.i_we)  r_overrun <= 1'b1;
          if (bus.i_ack) r_cnt     <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy    = (r_state == ST_HOLD);
  assign bus.o_valid   = (r_state == ST_HOLD);
  assign bus.o_class   = r_max_idx;
  assign bus.o_max     = r_max_val;
  assign bus.o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_argmax_layer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_argmax_layer : randomized scoreboard bench for argmax_layer      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_argmax_layer;
  localparam int N  = 10;
  localparam int DW = 2;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  argmax_layer_if #(.datatype_size(DW), .idx_width(IW)) bus ();

  argmax_layer #(.output_size(N), .datatype_size(DW), .idx_width(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { int cls; int mx; int at; } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: collected elements, hold flag, sticky overrun, current result.
  int elems[$];
  bit m_hold = 1'b0;
  bit m_ovr  = 1'b0;
  int m_cls  = 0;
  int m_max  = 0;

  function automatic void check_eq(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic void model_clear();
    elems.delete();
    m_hold = 1'b0;
    m_ovr  = 1'b0;
  endfunction

  // One clock cycle of stimulus; the model is advanced at the same edge.
  task automatic step(input bit we, input int d, input bit ack);
    bus.i_we   = we;
    bus.i_data = d[DW-1:0];
    bus.i_ack  = ack;
    @(posedge clk);
    if (m_hold) begin
      if (we)  m_ovr  = 1'b1;
      if (ack) m_hold = 1'b0;
    end else if (we) begin
      elems.push_back(d);
      if (elems.size() == N) begin
        m_cls = 0;
        m_max = elems[0];
        for (int i = 1; i < N; i++)
          if (elems[i] > m_max) begin
            m_max = elems[i];
            m_cls = i;
          end
        m_hold = 1'b1;
        q.push_back('{m_cls, m_max, cyc + 1});
        elems.delete();
      end
    end
    #1;
    bus.i_we  = 1'b0;
    bus.i_ack = 1'b0;
  endtask

  task automatic stream(input int v[N], input int max_gap);
    for (int i = 0; i < N; i++) begin
      step(1'b1, v[i], 1'b0);
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) step(1'b0, 0, 1'b0);
    end
  endtask

  task automatic idle_then_ack(input int gap);
    repeat (gap) step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b1);
  endtask

  // Monitor: per-cycle status against the model, scoreboard pop on each result.
  bit prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      check_eq("reset_outputs",
               int'({bus.o_valid, bus.o_busy, bus.o_overrun, bus.o_class, bus.o_max}), 0);
      prev_valid = 1'b0;
    end else begin
      check_eq("busy",    int'(bus.o_busy),    int'(m_hold));
      check_eq("valid",   int'(bus.o_valid),   int'(m_hold));
      check_eq("overrun", int'(bus.o_overrun), int'(m_ovr));
      if (bus.o_valid && !prev_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=valid required=no_result (t=%0t)", $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          check_eq("class",   int'(bus.o_class), e.cls);
          check_eq("max",     int'(bus.o_max),   e.mx);
          check_eq("latency", cyc,               e.at);
        end
      end else if (bus.o_valid && m_hold) begin
        check_eq("class_hold", int'(bus.o_class), m_cls);
        check_eq("max_hold",   int'(bus.o_max),   m_max);
      end
      prev_valid = bus.o_valid;
    end
  end

  initial begin
    int s[N];
    rst         = 1'b1;
    bus.i_we    = 1'b0;
    bus.i_data  = '0;
    bus.i_ack   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    s = '{0, 1, 2, 3, 0, 1, 2, 0, 1, 0};
    stream(s, 0);
    idle_then_ack(2);
    step(1'b0, 0, 1'b0);

    s = '{2, 0, 3, 3, 1, 3, 0, 0, 0, 0};
    stream(s, 3);
    idle_then_ack(1);

    s = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    stream(s, 0);
    step(1'b0, 0, 1'b0);
    step(1'b1, 2, 1'b0);
    step(1'b0, 0, 1'b0);
    step(1'b0, 0, 1'b1);

    s = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    stream(s, 0);
    idle_then_ack(0);

    // Abort mid-stream with an asynchronous reset between edges.
    for (int i = 0; i < 5; i++) step(1'b1, 3, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("async_reset_outputs",
             int'({bus.o_valid, bus.o_busy, bus.o_overrun, bus.o_class, bus.o_max}), 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    s = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 3};
    stream(s, 0);
    idle_then_ack(1);

    // Ack and a new first element in the same cycle: element dropped.
    s = '{1, 2, 0, 1, 2, 0, 1, 2, 0, 1};
    stream(s, 0);
    step(1'b1, 3, 1'b1);
    s = '{0, 1, 0, 1, 0, 2, 0, 2, 0, 0};
    stream(s, 0);
    idle_then_ack(1);

    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++) s[i] = int'($urandom_range(0, 3));
      stream(s, (r % 3));
      repeat ($urandom_range(0, 3)) step($urandom_range(0, 7) == 0, int'($urandom_range(0, 3)), 1'b0);
      step(1'b0, 0, 1'b1);
      if ($urandom_range(0, 1) == 1) step(1'b0, 0, 1'b1);
    end

    step(1'b0, 0, 1'b0);
    check_eq("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
